// File: rtl/mux_8_32_pkg.sv
// Shared definitions for the byte-to-word packer: FSM encoding, default geometry, counter sizing.
package mux_8_32_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam int unsigned DEF_BYTE_W  = 8;
  localparam int unsigned DEF_BYTES   = 4;
  localparam int unsigned DEF_MAX_GAP = 3;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_8_32_byte_shift_reg.sv
// Load-at-index byte register with synchronous clear; byte 0 lands in the MSB lane.
// o_word shows the stored bytes with the current load already merged in.
module byte_shift_reg
  import mux_8_32_pkg::*;
#(
  parameter int unsigned BYTE_W = DEF_BYTE_W,
  parameter int unsigned BYTES  = DEF_BYTES,
  parameter int unsigned IDX_W  = cnt_w(DEF_BYTES)
) (
  input  logic                     i_clk,
  input  logic                     i_clr,
  input  logic                     i_load,
  input  logic [IDX_W-1:0]         i_idx,
  input  logic [BYTE_W-1:0]        i_dat,
  output logic [BYTE_W*BYTES-1:0]  o_word
);

  logic [BYTES-1:0][BYTE_W-1:0] r_bytes;
  logic [BYTES-1:0][BYTE_W-1:0] w_merged;

  // Merged view lets the owner capture the full word on the same edge as the last byte.
  always_comb begin
    w_merged = r_bytes;
    for (int i = 0; i < int'(BYTES); i++) begin
      if (i_load && (i_idx == IDX_W'(i))) begin
        w_merged[BYTES-1-i] = i_dat;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_bytes <= '0;
    end else if (i_load) begin
      r_bytes <= w_merged;
    end
  end

  assign o_word = w_merged;

endmodule

// File: rtl/mux_8_32.sv
// Packs BYTES valid-qualified bytes into one word with a one-cycle valid_out pulse.
// Partial words are dropped with an err_out pulse after MAX_GAP idle cycles (0 disables).
module mux_8_32
  import mux_8_32_pkg::*;
#(
  parameter int unsigned BYTE_W  = DEF_BYTE_W,
  parameter int unsigned BYTES   = DEF_BYTES,
  parameter int unsigned MAX_GAP = DEF_MAX_GAP
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [BYTE_W-1:0]        data_in,
  output logic [BYTE_W*BYTES-1:0]  data_out,
  output logic                     valid_out,
  output logic                     err_out,
  output logic                     busy
);

  localparam int unsigned BCNT_W  = cnt_w(BYTES);
  localparam int unsigned GCNT_W  = cnt_w(MAX_GAP + 1);
  localparam int unsigned GAP_LIM = (MAX_GAP == 0) ? 0 : MAX_GAP - 1;

  state_t                    r_state;
  logic [BCNT_W-1:0]         r_byte_cnt;
  logic [GCNT_W-1:0]         r_gap_cnt;
  logic [BYTE_W*BYTES-1:0]   r_data_out;
  logic                      r_valid_out;
  logic                      r_err_out;

  logic                      w_last;
  logic                      w_done;
  logic                      w_timeout;
  logic [BYTE_W*BYTES-1:0]   w_word;

  assign w_last = (r_byte_cnt == BCNT_W'(BYTES - 1));
  assign w_done = valid_in && (r_state == ST_COLLECT) && w_last;

  // Fires on the MAX_GAP-th idle cycle; a byte in that cycle takes precedence.
  assign w_timeout = (MAX_GAP != 0) && !valid_in && (r_state == ST_COLLECT) &&
                     (r_gap_cnt == GCNT_W'(GAP_LIM));

  byte_shift_reg #(
    .BYTE_W (BYTE_W),
    .BYTES  (BYTES),
    .IDX_W  (BCNT_W)
  ) u_shift (
    .i_clk  (clk_4f),
    .i_clr  (reset || w_done || w_timeout),
    .i_load (valid_in),
    .i_idx  (r_byte_cnt),
    .i_dat  (data_in),
    .o_word (w_word)
  );

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_byte_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_err_out   <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      r_err_out   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (valid_in) begin
            r_byte_cnt <= BCNT_W'(1);
            r_gap_cnt  <= '0;
            r_state    <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (valid_in) begin
            r_gap_cnt <= '0;
            if (w_last) begin
              r_data_out  <= w_word;
              r_valid_out <= 1'b1;
              r_byte_cnt  <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
            end
          end else if (w_timeout) begin
            r_err_out  <= 1'b1;
            r_byte_cnt <= '0;
            r_gap_cnt  <= '0;
            r_state    <= ST_IDLE;
          end else if (MAX_GAP != 0) begin
            r_gap_cnt <= r_gap_cnt + GCNT_W'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_byte_cnt <= '0;
          r_gap_cnt  <= '0;
        end
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign err_out   = r_err_out;
  assign busy      = (r_state == ST_COLLECT);

endmodule

// File: tb/tb_mux_8_32.sv
// Randomized and directed bench for mux_8_32 with a queue-based word model and a decoupled monitor.
module tb_mux_8_32;

  localparam int BYTES   = 4;
  localparam int MAX_GAP = 3;

  logic        clk_4f = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [31:0] data_out;
  logic        valid_out;
  logic        err_out;
  logic        busy;

  typedef struct packed {
    logic [31:0] data;
    logic        vo;
    logic        eo;
    logic        busy;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  part[$];
  int          gap = 0;
  logic [31:0] last_word = '0;
  int          checks = 0;
  int          errors = 0;

  mux_8_32 dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .err_out   (err_out),
    .busy      (busy)
  );

  always #5 clk_4f = ~clk_4f;

  // Reference: bytes accumulate in a list; a full list becomes a word, a long idle run empties it.
  function automatic exp_t model(input logic r, input logic v, input logic [7:0] d);
    exp_t e;
    logic [31:0] w;
    e = '0;
    if (r) begin
      part.delete();
      gap = 0;
      last_word = '0;
    end else if (v) begin
      part.push_back(d);
      gap = 0;
      if (part.size() == BYTES) begin
        w = '0;
        foreach (part[i]) w = {w[23:0], part[i]};
        last_word = w;
        e.vo = 1'b1;
        part.delete();
      end
    end else if (part.size() != 0) begin
      gap++;
      if (MAX_GAP != 0 && gap == MAX_GAP) begin
        e.eo = 1'b1;
        part.delete();
        gap = 0;
      end
    end
    e.data = last_word;
    e.busy = (part.size() != 0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    exp_t e;
    reset    = r;
    valid_in = v;
    data_in  = v ? d : 8'($urandom);
    e = model(r, v, d);
    @(posedge clk_4f);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: compares every registered output cycle against the popped expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_4f);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data_out",  data_out,          e.data);
        chk("valid_out", {31'b0, valid_out}, {31'b0, e.vo});
        chk("err_out",   {31'b0, err_out},   {31'b0, e.eo});
        chk("busy",      {31'b0, busy},      {31'b0, e.busy});
        chk("vo_eo_excl", {31'b0, valid_out & err_out}, 32'h0);
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);

    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    idle(2);

    for (int i = 1; i <= 8; i++) send(8'(i));
    idle(2);

    send(8'h11); send(8'h22); idle(2); send(8'h33); send(8'h44);
    idle(2);

    send(8'h11); send(8'h22); idle(3);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    idle(1);

    send(8'h11); send(8'h22); step(1'b1, 1'b1, 8'h99);
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    idle(2);

    send(8'h11); send(8'h22); send(8'h33); idle(2); send(8'h44);
    idle(1);

    send(8'h5A); idle(5);

    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 199) == 0) step(1'b1, 1'($urandom), 8'($urandom));
      else send(8'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(4);

    @(negedge clk_4f);
    @(negedge clk_4f);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
